// File: rtl/bitcoin_nonce_search.sv
`default_nettype none
// ============================================================================
// Module   : bitcoin_nonce_search
// Function : Reads a 20-word block header, computes the first-block SHA-256
//            midstate once, then sweeps a nonce range through NUM_LANES
//            parallel second-block compression lanes. Dump mode writes each
//            lane's H0. Search mode stops at the first H0 below target.
// Revision : 1.0  initial release
// ============================================================================
module bitcoin_nonce_search #(
  parameter int NUM_LANES = 16,
  parameter int NUM_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  input  logic [31:0] nonce_base,
  input  logic [31:0] nonce_count,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [31:0] found_nonce,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int IW = $clog2(NUM_LANES + 1);

  typedef logic [7:0][31:0]  hstate_t;  // [0]=a .. [7]=h
  typedef logic [15:0][31:0] sched_t;   // [0] is the word used this round

  typedef enum logic [3:0] {
    S_IDLE, S_READ, S_MID, S_LOAD, S_RUN, S_FIN, S_WRITE, S_CHECK, S_REPORT
  } state_t;

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam hstate_t IV_INIT = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                 32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic hstate_t sha_round(input hstate_t s, input logic [31:0] w, input logic [31:0] k);
    logic [31:0] t1, t2;
    hstate_t r;
    t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
        + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
    t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
        + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    r = {s[6], s[5], s[4], s[3] + t1, s[2], s[1], s[0], t1 + t2};
    return r;
  endfunction

  // Shift the 16-word window and append W[t+16]; the tail is harmless after round 47.
  function automatic sched_t sched_next(input sched_t s);
    logic [31:0] s0, s1;
    s0 = rotr(s[1], 7) ^ rotr(s[1], 18) ^ (s[1] >> 3);
    s1 = rotr(s[14], 17) ^ rotr(s[14], 19) ^ (s[14] >> 10);
    return {s1 + s[9] + s0 + s[0], s[15:1]};
  endfunction

  state_t          state_q, state_d;
  logic            mode_q, mode_d, found_q, found_d, mem_we_q, mem_we_d;
  logic [15:0]     msg_base_q, msg_base_d, out_base_q, out_base_d, mem_addr_q, mem_addr_d;
  logic [31:0]     nbase_q, nbase_d, ncount_q, ncount_d, target_q, target_d;
  logic [31:0]     found_nonce_q, found_nonce_d, mem_wdata_q, mem_wdata_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [32:0]     batch_q, batch_d;
  sched_t          sched_q, sched_d;
  hstate_t         hs_q, hs_d, mid_q, mid_d;
  logic [2:0][31:0] ext_q, ext_d;
  hstate_t         lst_q [NUM_LANES];
  hstate_t         lst_d [NUM_LANES];
  sched_t          lw_q [NUM_LANES];
  sched_t          lw_d [NUM_LANES];
  logic [31:0]     h0_q [NUM_LANES];
  logic [31:0]     h0_d [NUM_LANES];

  logic [31:0]        lane_nonce [NUM_LANES];
  hstate_t            lane_next [NUM_LANES];
  logic [NUM_LANES-1:0] lane_active, lane_hit;
  logic [NUM_LANES:0] act_ext;
  logic [6:0]         word_idx;
  logic [32:0]        batch_next;
  logic               batch_more, hit;
  logic [31:0]        hit_nonce, wr_data;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_nonce[i]  = nbase_q + batch_q[31:0] + 32'(i);
    assign lane_active[i] = (batch_q + 33'(i)) < {1'b0, ncount_q};
    assign lane_hit[i]    = lane_active[i] && (h0_q[i] < target_q);
    assign lane_next[i]   = sha_round(lst_q[i], lw_q[i][0], K_TABLE[cnt_q[5:0]]);
  end

  assign act_ext    = {1'b0, lane_active};
  assign word_idx   = cnt_q - 7'd1;
  assign batch_next = batch_q + 33'(NUM_LANES);
  assign batch_more = batch_next < {1'b0, ncount_q};

  assign done           = (state_q == S_IDLE);
  assign found          = found_q;
  assign found_nonce    = found_nonce_q;
  assign mem_clk        = clk;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;

  // Lowest-index hit priority encode and write-lane data mux
  always_comb begin
    hit       = 1'b0;
    hit_nonce = '0;
    wr_data   = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (lane_hit[i]) begin
        hit       = 1'b1;
        hit_nonce = lane_nonce[i];
      end
      if (idx_q == IW'(i)) wr_data = h0_q[i];
    end
  end

  // Next-state, datapath and memory-port logic
  always_comb begin
    state_d = state_q;  mode_d = mode_q;  found_d = found_q;  found_nonce_d = found_nonce_q;
    msg_base_d = msg_base_q;  out_base_d = out_base_q;  nbase_d = nbase_q;
    ncount_d = ncount_q;  target_d = target_q;  cnt_d = cnt_q;  idx_d = idx_q;
    batch_d = batch_q;  sched_d = sched_q;  hs_d = hs_q;  mid_d = mid_q;  ext_d = ext_q;
    lst_d = lst_q;  lw_d = lw_q;  h0_d = h0_q;
    mem_we_d = 1'b0;  mem_addr_d = mem_addr_q;  mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: if (start) begin
        mode_d = mode;  msg_base_d = message_addr;  out_base_d = output_addr;
        nbase_d = nonce_base;  ncount_d = nonce_count;  target_d = target;
        found_d = 1'b0;  found_nonce_d = '0;  batch_d = '0;  cnt_d = '0;
        if (nonce_count != 32'd0) begin
          state_d    = S_READ;
          mem_addr_d = message_addr;  // word 0 address is out during the first READ cycle
        end
      end
      S_READ: begin
        if (cnt_q < 7'(NUM_WORDS - 1)) mem_addr_d = msg_base_q + 16'(cnt_q) + 16'd1;
        if (cnt_q != 7'd0) begin
          if (word_idx < 7'd16)       sched_d[word_idx[3:0]] = mem_read_data;
          else if (word_idx == 7'd16) ext_d[0] = mem_read_data;
          else if (word_idx == 7'd17) ext_d[1] = mem_read_data;
          else if (word_idx == 7'd18) ext_d[2] = mem_read_data;
        end
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'(NUM_WORDS)) begin
          state_d = S_MID;  cnt_d = '0;  hs_d = IV_INIT;
        end
      end
      S_MID: begin
        if (cnt_q == 7'd64) begin
          for (int j = 0; j < 8; j++) mid_d[j] = IV_INIT[j] + hs_q[j];
          state_d = S_LOAD;
        end else begin
          hs_d    = sha_round(hs_q, sched_q[0], K_TABLE[cnt_q[5:0]]);
          sched_d = sched_next(sched_q);
          cnt_d   = cnt_q + 7'd1;
        end
      end
      S_LOAD: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          lst_d[i] = mid_q;
          lw_d[i]  = {32'd640, 320'd0, 32'h80000000, lane_nonce[i], ext_q[2], ext_q[1], ext_q[0]};
        end
        cnt_d = '0;  state_d = S_RUN;
      end
      S_RUN: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          lst_d[i] = lane_next[i];
          lw_d[i]  = sched_next(lw_q[i]);
        end
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd63) state_d = S_FIN;
      end
      S_FIN: begin
        for (int i = 0; i < NUM_LANES; i++) h0_d[i] = mid_q[0] + lst_q[i][0];
        idx_d   = '0;
        state_d = mode_q ? S_CHECK : S_WRITE;
      end
      S_WRITE: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = out_base_q + batch_q[15:0] + 16'(idx_q);
        mem_wdata_d = wr_data;
        idx_d       = idx_q + IW'(1);
        if (!act_ext[idx_q + IW'(1)]) begin
          batch_d = batch_next;
          state_d = batch_more ? S_LOAD : S_IDLE;
        end
      end
      S_CHECK: begin
        cnt_d = '0;
        if (hit) begin
          found_d = 1'b1;  found_nonce_d = hit_nonce;  state_d = S_REPORT;
        end else begin
          batch_d = batch_next;
          state_d = batch_more ? S_LOAD : S_REPORT;
        end
      end
      S_REPORT: begin
        mem_we_d = 1'b1;
        if (cnt_q == 7'd0) begin
          mem_addr_d = out_base_q;  mem_wdata_d = {31'd0, found_q};  cnt_d = 7'd1;
        end else begin
          mem_addr_d = out_base_q + 16'd1;  mem_wdata_d = found_nonce_q;  state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;  mode_q <= 1'b0;  found_q <= 1'b0;  found_nonce_q <= '0;
      msg_base_q <= '0;  out_base_q <= '0;  nbase_q <= '0;  ncount_q <= '0;  target_q <= '0;
      cnt_q <= '0;  idx_q <= '0;  batch_q <= '0;  sched_q <= '0;  hs_q <= '0;  mid_q <= '0;
      ext_q <= '0;  mem_we_q <= 1'b0;  mem_addr_q <= '0;  mem_wdata_q <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        lst_q[i] <= '0;  lw_q[i] <= '0;  h0_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;  mode_q <= mode_d;  found_q <= found_d;  found_nonce_q <= found_nonce_d;
      msg_base_q <= msg_base_d;  out_base_q <= out_base_d;  nbase_q <= nbase_d;
      ncount_q <= ncount_d;  target_q <= target_d;  cnt_q <= cnt_d;  idx_q <= idx_d;
      batch_q <= batch_d;  sched_q <= sched_d;  hs_q <= hs_d;  mid_q <= mid_d;  ext_q <= ext_d;
      mem_we_q <= mem_we_d;  mem_addr_q <= mem_addr_d;  mem_wdata_q <= mem_wdata_d;
      lst_q <= lst_d;  lw_q <= lw_d;  h0_q <= h0_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bitcoin_nonce_search.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitcoin_nonce_search
// Function : Self-checking bench for bitcoin_nonce_search (16- and 4-lane
//            instances sharing one memory model), with a golden SHA-256
//            model and a write scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_bitcoin_nonce_search;

  typedef logic [7:0][31:0]  hv_t;
  typedef logic [15:0][31:0] blk_t;
  typedef struct packed { logic [15:0] addr; logic [31:0] data; } wr_t;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam hv_t IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  // Genesis block header, big-endian words
  localparam logic [31:0] HDR [20] = '{
    32'h01000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h3ba3edfd,
    32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3, 32'h888a5132,
    32'h3a9fb8aa, 32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c
  };

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0, sel16 = 1'b1, init_mem = 1'b0;
  logic [15:0] message_addr = 16'h0000, output_addr = 16'h0100;
  logic [31:0] nonce_base = '0, nonce_count = '0, target = '0;
  logic        start16, start4;
  logic        done16, found16, mclk16, we16, done4, found4, mclk4, we4;
  logic [31:0] fn16, wd16, fn4, wd4, mem_read_data;
  logic [15:0] addr16, addr4;
  logic        mem_we, done_sel;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem [65536];
  int          write_count = 0;
  int          n_checks = 0, n_fail = 0;
  wr_t         exp_q [$];
  hv_t         mid;

  always #5 clk = ~clk;

  assign start16        = start && sel16;
  assign start4         = start && !sel16;
  assign mem_we         = sel16 ? we16 : we4;
  assign mem_addr       = sel16 ? addr16 : addr4;
  assign mem_write_data = sel16 ? wd16 : wd4;
  assign done_sel       = sel16 ? done16 : done4;

  bitcoin_nonce_search #(.NUM_LANES(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .mode(mode), .message_addr(message_addr),
    .output_addr(output_addr), .nonce_base(nonce_base), .nonce_count(nonce_count), .target(target),
    .done(done16), .found(found16), .found_nonce(fn16), .mem_clk(mclk16), .mem_we(we16),
    .mem_addr(addr16), .mem_write_data(wd16), .mem_read_data(mem_read_data));

  bitcoin_nonce_search #(.NUM_LANES(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .mode(mode), .message_addr(message_addr),
    .output_addr(output_addr), .nonce_base(nonce_base), .nonce_count(nonce_count), .target(target),
    .done(done4), .found(found4), .found_nonce(fn4), .mem_clk(mclk4), .mem_we(we4),
    .mem_addr(addr4), .mem_write_data(wd4), .mem_read_data(mem_read_data));

  // Synchronous memory: one-cycle read latency, writes commit on edges with mem_we=1
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 20; i++) mem[i] <= HDR[i];
      for (int i = 256; i < 512; i++) mem[i] <= 32'hDEADBEEF;
      write_count <= 0;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_write_data;
      write_count   <= write_count + 1;
    end
    mem_read_data <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every presented write must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_write: observed addr %04h data %08h, expected no write", mem_addr, mem_write_data);
      end
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {16'h0, mem_addr}, {16'h0, e.addr});
        check("wr_data", mem_write_data, e.data);
      end
    end
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic hv_t compress(input hv_t hin, input blk_t blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    hv_t r;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = blk[t];
      else w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    end
    a = hin[0]; b = hin[1]; c = hin[2]; d = hin[3]; e = hin[4]; f = hin[5]; g = hin[6]; h = hin[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    r = {hin[7] + h, hin[6] + g, hin[5] + f, hin[4] + e, hin[3] + d, hin[2] + c, hin[1] + b, hin[0] + a};
    return r;
  endfunction

  function automatic logic [31:0] golden(input logic [31:0] nonce);
    blk_t b;
    hv_t  r;
    b = {32'd640, 320'd0, 32'h80000000, nonce, HDR[18], HDR[17], HDR[16]};
    r = compress(mid, b);
    return r[0];
  endfunction

  task automatic push(input logic [15:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;  e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic init_memory();
    @(negedge clk) init_mem = 1'b1;
    @(negedge clk) init_mem = 1'b0;
  endtask

  task automatic start_job(input logic md, input logic [31:0] base, input logic [31:0] cnt, input logic [31:0] tgt);
    @(negedge clk);
    mode = md;  nonce_base = base;  nonce_count = cnt;  target = tgt;  output_addr = 16'h0100;  start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (cnt != 0) check("done_falls", {31'd0, done_sel}, 32'd0);
  endtask

  // Counts edges after acceptance until done; optionally pulses an ignored start mid-job
  task automatic wait_done(input int poke_at, output int cycles);
    logic md_save;
    md_save = mode;
    cycles = 0;
    while (cycles < 3000) begin
      @(posedge clk);
      cycles++;
      #1;
      if (poke_at != 0 && cycles == poke_at) begin
        start = 1'b1;  output_addr = 16'h0200;  mode = ~md_save;
      end
      if (poke_at != 0 && cycles == poke_at + 1) begin
        start = 1'b0;  output_addr = 16'h0100;  mode = md_save;
      end
      if (done_sel) break;
    end
    check("done_returned", {31'd0, done_sel}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int cyc;
    int batches;
    logic [15:0] prev_addr;
    logic        exp_found;
    logic [31:0] exp_n, tgt;
    blk_t        blk0;

    for (int i = 0; i < 16; i++) blk0[i] = HDR[i];
    mid = compress(IV, blk0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_done16", {31'd0, done16}, 32'd1);
    check("rst_found16", {31'd0, found16}, 32'd0);
    check("rst_fnonce16", fn16, 32'd0);
    check("rst_we16", {31'd0, we16}, 32'd0);
    check("rst_addr16", {16'd0, addr16}, 32'd0);
    check("rst_wdata16", wd16, 32'd0);
    check("rst_done4", {31'd0, done4}, 32'd1);
    check("mem_clk16", {31'd0, mclk16}, {31'd0, clk});
    check("mem_clk4", {31'd0, mclk4}, {31'd0, clk});
    @(negedge clk) reset = 1'b0;

    // Dump, full batch, 16 lanes
    sel16 = 1'b1;
    init_memory();
    for (int i = 0; i < 16; i++) push(16'h0100 + 16'(i), golden(32'(i)));
    start_job(1'b0, 32'd0, 32'd16, 32'd0);
    wait_done(0, cyc);
    check("full_cycles", cyc, 32'd168);
    check("full_queue", exp_q.size(), 32'd0);
    check("full_writes", write_count, 32'd16);
    check("full_mem10F", mem[16'h010F], golden(32'd15));

    // Dump, partial batch, 4 lanes, with an ignored start during RUN
    sel16 = 1'b0;
    init_memory();
    for (int i = 0; i < 10; i++) push(16'h0100 + 16'(i), golden(32'(i)));
    start_job(1'b0, 32'd0, 32'd10, 32'd0);
    wait_done(100, cyc);
    check("part_cycles", cyc, 32'd294);
    check("part_queue", exp_q.size(), 32'd0);
    check("part_writes", write_count, 32'd10);
    check("part_mem109", mem[16'h0109], golden(32'd9));
    check("part_mem10A", mem[16'h010A], 32'hDEADBEEF);

    // Search, hit
    init_memory();
    tgt = golden(32'd5) + 32'd1;
    exp_found = 1'b0;  exp_n = '0;
    for (int n = 15; n >= 0; n--) if (golden(32'(n)) < tgt) begin exp_found = 1'b1; exp_n = 32'(n); end
    batches = exp_found ? int'(exp_n[31:2]) + 1 : 4;
    push(16'h0100, {31'd0, exp_found});
    push(16'h0101, exp_found ? exp_n : 32'd0);
    start_job(1'b1, 32'd0, 32'd16, tgt);
    wait_done(0, cyc);
    check("hit_found", {31'd0, found4}, {31'd0, exp_found});
    check("hit_nonce", fn4, exp_found ? exp_n : 32'd0);
    check("hit_cycles", cyc, 32'(86 + batches * 67 + 2));
    check("hit_queue", exp_q.size(), 32'd0);
    check("hit_mem100", mem[16'h0100], {31'd0, exp_found});

    // Zero count: no memory access, found cleared, done stays high
    init_memory();
    prev_addr = addr4;
    start_job(1'b1, 32'd0, 32'd0, 32'hFFFFFFFF);
    check("zero_done", {31'd0, done4}, 32'd1);
    repeat (5) @(negedge clk);
    check("zero_done_hold", {31'd0, done4}, 32'd1);
    check("zero_found", {31'd0, found4}, 32'd0);
    check("zero_addr", {16'd0, addr4}, {16'd0, prev_addr});
    check("zero_writes", write_count, 32'd0);

    // Search, miss with nonce wrap
    init_memory();
    push(16'h0100, 32'd0);
    push(16'h0101, 32'd0);
    start_job(1'b1, 32'hFFFFFFFE, 32'd4, 32'd0);
    wait_done(0, cyc);
    check("miss_found", {31'd0, found4}, 32'd0);
    check("miss_nonce", fn4, 32'd0);
    check("miss_cycles", cyc, 32'd155);
    check("miss_queue", exp_q.size(), 32'd0);

    // Dump across the nonce wrap
    init_memory();
    for (int i = 0; i < 4; i++) push(16'h0100 + 16'(i), golden(32'hFFFFFFFE + 32'(i)));
    start_job(1'b0, 32'hFFFFFFFE, 32'd4, 32'd0);
    wait_done(0, cyc);
    check("wrap_cycles", cyc, 32'd156);
    check("wrap_queue", exp_q.size(), 32'd0);

    // Reset abort during WRITE, then a fresh job
    init_memory();
    for (int i = 0; i < 10; i++) push(16'h0100 + 16'(i), golden(32'(i)));
    start_job(1'b0, 32'd0, 32'd10, 32'd0);
    cyc = 0;
    while (cyc < 400 && !we4) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_write", {31'd0, we4}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_we", {31'd0, we4}, 32'd0);
    check("abort_idle", {31'd0, done4}, 32'd1);
    exp_q.delete();
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_no_commit", mem[16'h0100], 32'hDEADBEEF);
    check("abort_writes", write_count, 32'd0);
    for (int i = 0; i < 6; i++) push(16'h0100 + 16'(i), golden(32'd20 + 32'(i)));
    start_job(1'b0, 32'd20, 32'd6, 32'd0);
    wait_done(0, cyc);
    check("rerun_cycles", cyc, 32'd224);
    check("rerun_queue", exp_q.size(), 32'd0);
    check("rerun_writes", write_count, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
